muldiv: RTL and testbench

MULDIV -- requirements
Module: muldiv

---
 rtl/muldiv.sv | 173 +++++++++++++++++
 tb/tb_muldiv.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv.sv
// muldiv: iterative 32-bit multiply/divide unit with HI/LO result registers.
// Signed and unsigned multiply (shift-add) and divide (restoring shift-subtract)
// work on operand magnitudes. A final FIX cycle applies the sign correction and
// writes HI/LO.
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   start, op, a, b   - operation request (op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   whi, wlo, wd      - direct HI/LO writes, honoured only while idle
//   busy, done        - operation in progress / one-cycle completion pulse
//   hi, lo            - HI (product high / remainder), LO (product low / quotient)
module muldiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        whi,
  input  logic        wlo,
  input  logic [31:0] wd,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;
  // Count 0 loads the magnitudes; counts 1..32 are the 32 single-bit iterations.
  localparam logic [CW-1:0] LAST_CNT = CW'(W);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [W-1:0]      a_q, a_d, b_q, b_d;
  logic [2*W-1:0]    acc_q, acc_d;
  logic [W-1:0]      rem_q, rem_d, quo_q, quo_d;
  logic [W-1:0]      hi_q, hi_d, lo_q, lo_d;
  logic              busy_q, busy_d, done_q, done_d;

  // Operand magnitudes and signs of the latched operation.
  logic              is_signed, a_neg, b_neg;
  logic [W-1:0]      a_mag, b_mag;
  assign is_signed = ~op_q[0];
  assign a_neg     = is_signed & a_q[W-1];
  assign b_neg     = is_signed & b_q[W-1];
  assign a_mag     = a_neg ? (W'(0) - a_q) : a_q;
  assign b_mag     = b_neg ? (W'(0) - b_q) : b_q;

  // One shift-add multiply step: multiplier sits in acc low half, shifts right.
  logic [W:0]        mul_sum;
  logic [2*W-1:0]    acc_next;
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_mag} : (W+1)'(0));
  assign acc_next = {mul_sum, acc_q[W-1:1]};

  // One restoring divide step on the 33-bit shifted partial remainder.
  logic [W:0]        rem_sh;
  logic              div_ge;
  logic [W-1:0]      rem_sub;
  assign rem_sh  = {rem_q, quo_q[W-1]};
  assign div_ge  = rem_sh >= {1'b0, b_mag};
  assign rem_sub = W'(rem_sh - {1'b0, b_mag});

  // Sign-corrected results used in FIX.
  logic [2*W-1:0]    prod_fix;
  logic [W-1:0]      quo_fix, rem_fix;
  assign prod_fix = (a_neg ^ b_neg) ? ((2*W)'(0) - acc_q) : acc_q;
  assign quo_fix  = (a_neg ^ b_neg) ? (W'(0) - quo_q) : quo_q;
  assign rem_fix  = a_neg ? (W'(0) - rem_q) : rem_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (whi) hi_d = wd;
        if (wlo) lo_d = wd;
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          state_d = op[1] ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        acc_d = (cnt_q == '0) ? {W'(0), a_mag} : acc_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) state_d = S_FIX;
      end
      S_DIV: begin
        if (cnt_q == '0) begin
          rem_d = '0;
          quo_d = a_mag;
        end else begin
          rem_d = div_ge ? rem_sub : rem_sh[W-1:0];
          quo_d = {quo_q[W-2:0], div_ge};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) state_d = S_FIX;
      end
      S_FIX: begin
        if (!op_q[1]) begin
          hi_d = prod_fix[2*W-1:W];
          lo_d = prod_fix[W-1:0];
        end else if (b_q == '0) begin
          // Divide by zero: all-ones quotient, dividend passed through.
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: directed corner cases, randomized operations
// against an arithmetic reference model, busy-time interference, back-to-back
// starts, HI/LO writes and reset abort.
module tb_muldiv;

  logic        clk = 1'b0;
  logic        reset, start, whi, wlo;
  logic [1:0]  op;
  logic [31:0] a, b, wd;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  muldiv dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .whi(whi), .wlo(wlo), .wd(wd), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference model: {hi, lo} from plain arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint p;
    int sx, sy, q, r;
    case (o)
      2'b00: begin
        p = longint'($signed(x)) * longint'($signed(y));
        return p;
      end
      2'b01: return {32'h0, x} * {32'h0, y};
      2'b10: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        sx = x; sy = y;
        q = sx / sy; r = sx % sy;
        return {r, q};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issue one operation from an idle (or done) cycle and wait for done.
  // Leaves the bench #1 after the done edge.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output bit busy_bad);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
    lat = 0; busy_bad = 1'b0;
    while (!done && lat < 100) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; whi = 1'b0; wlo = 1'b0; op = '0; a = '0; b = '0; wd = '0;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if ({busy, done, hi, lo} !== 66'h0) begin
      failures++;
      $display("FAIL reset_state busy=%b done=%b hi=%h lo=%h expected all zero", busy, done, hi, lo);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  ops [7] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b11, 2'b11, 2'b10};
    logic [31:0] as  [7] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h0, 32'hFFFFFFF9, 32'h7, 32'h5, 32'h80000000};
    logic [31:0] bs  [7] = '{32'hFFFFFFFF, 32'h7, 32'hFFFFFFFF, 32'h2, 32'h2, 32'h0, 32'hFFFFFFFF};
    logic [63:0] exp [7] = '{64'hFFFFFFFE_00000001, 64'hFFFFFFFF_FFFFFFEB, 64'h0,
                             64'hFFFFFFFF_FFFFFFFD, 64'h1_00000003, 64'h5_FFFFFFFF,
                             64'h0_80000000};
    int lat; bit bb;
    for (int i = 0; i < 7; i++) begin
      do_op(ops[i], as[i], bs[i], lat, bb);
      checks++;
      if ({hi, lo} !== exp[i]) begin
        failures++;
        $display("FAIL directed_%0d hi:lo=%h expected %h", i, {hi, lo}, exp[i]);
      end
      checks++;
      if (lat != 34 || bb || busy !== 1'b0) begin
        failures++;
        $display("FAIL directed_timing_%0d latency=%0d busy_gap=%b busy_at_done=%b expected 34/0/0", i, lat, bb, busy);
      end
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL done_one_cycle done=%b expected 0", done);
    end
  endtask

  task automatic test_random();
    int lat; bit bb;
    logic [1:0] o; logic [31:0] x, y; logic [63:0] e;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = 32'($urandom_range(0, 9));
        1: y = 32'hFFFFFFFF - 32'($urandom_range(0, 9));
        default: y = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) x = 32'h80000000;
      e = model(o, x, y);
      do_op(o, x, y, lat, bb);
      checks++;
      if ({hi, lo} !== e || lat != 34) begin
        failures++;
        $display("FAIL random_%0d op=%0d a=%h b=%h hi:lo=%h lat=%0d expected %h lat=34", i, o, x, y, {hi, lo}, lat, e);
      end
      tick();
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
    tick();                              // E0
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();  // now after E0+9
    start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3; whi = 1'b1; wd = 32'd1234;
    tick();                              // E0+10
    start = 1'b0; whi = 1'b0;
    lat = 10;
    while (!done && lat < 100) begin tick(); lat++; end
    checks++;
    if (hi !== 32'd2 || lo !== 32'd14 || lat != 34) begin
      failures++;
      $display("FAIL busy_ignore hi=%h lo=%h lat=%0d expected 2/e/34", hi, lo, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit bb;
    do_op(2'b01, 32'd6, 32'd7, lat, bb);
    start = 1'b1; op = 2'b11; a = 32'd50; b = 32'd8;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back_accept busy=%b done=%b expected 1/0", busy, done);
    end
    lat = 0;
    while (!done && lat < 100) begin tick(); lat++; end
    checks++;
    if (hi !== 32'd2 || lo !== 32'd6 || lat != 34) begin
      failures++;
      $display("FAIL back_to_back_result hi=%h lo=%h lat=%0d expected 2/6/34", hi, lo, lat);
    end
  endtask

  task automatic test_write_regs();
    int lat; bit bb;
    logic [31:0] v0, v1, v2;
    v0 = $urandom; v1 = $urandom; v2 = $urandom;
    tick();
    whi = 1'b1; wd = v0; tick(); whi = 1'b0;
    wlo = 1'b1; wd = v1; tick(); wlo = 1'b0;
    checks++;
    if (hi !== v0 || lo !== v1) begin
      failures++;
      $display("FAIL write_single hi=%h lo=%h expected %h/%h", hi, lo, v0, v1);
    end
    whi = 1'b1; wlo = 1'b1; wd = v2; tick(); whi = 1'b0; wlo = 1'b0;
    checks++;
    if (hi !== v2 || lo !== v2) begin
      failures++;
      $display("FAIL write_both hi=%h lo=%h expected %h", hi, lo, v2);
    end
    // Write together with an accepted start: visible during busy, then overwritten.
    whi = 1'b1; wlo = 1'b1; wd = v0;
    start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
    tick();
    start = 1'b0; whi = 1'b0; wlo = 1'b0;
    checks++;
    if (hi !== v0 || lo !== v0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL write_with_start hi=%h lo=%h busy=%b expected %h/%h/1", hi, lo, busy, v0, v0);
    end
    lat = 0;
    while (!done && lat < 100) begin tick(); lat++; end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd81) begin
      failures++;
      $display("FAIL write_overwritten hi=%h lo=%h expected 0/51", hi, lo);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int lat; bit bb; bit saw_done;
    start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3;
    tick();                              // E0
    start = 1'b0;
    for (int i = 0; i < 11; i++) tick(); // after E0+11
    reset = 1'b1; start = 1'b1; whi = 1'b1; wlo = 1'b1; wd = 32'hDEADBEEF;
    tick();                              // E0+12
    reset = 1'b0; start = 1'b0; whi = 1'b0; wlo = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      failures++;
      $display("FAIL reset_abort busy=%b done=%b hi=%h lo=%h expected 0/0/0/0", busy, done, hi, lo);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
      tick();
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL reset_abort_quiet activity after aborted operation");
    end
    do_op(2'b01, 32'd3, 32'd4, lat, bb);
    checks++;
    if (hi !== 32'h0 || lo !== 32'hC || lat != 34) begin
      failures++;
      $display("FAIL after_reset_mult hi=%h lo=%h lat=%0d expected 0/c/34", hi, lo, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_write_regs();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
